cgra_config_loader: RTL and testbench

Serial bitstream loader for the 4x3 CGRA configuration chain. Accepts configuration words from the host over a valid/ready interface and shifts them, LSB-first, into the head of the daisy-chained ConfigCell/const chain. It emits one bit per enabled cycle together with a shift-enable that drives the chain's clock gate. It counts exactly CHAIN_BITS bits, discards surplus bits of the final word, and signals completion.

---
 rtl/cgra_config_loader_if.sv | 12 +
 rtl/cgra_config_loader.sv | 113 +++++++++++
 tb/tb_cgra_config_loader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cgra_config_loader_if.sv
// Host-side word channel for the CGRA configuration loader.
// The host drives cfg_word/cfg_valid; the loader answers with cfg_ready.
interface cgra_config_loader_if #(
    parameter int WORD_WIDTH = 32
);
    logic [WORD_WIDTH-1:0] cfg_word;
    logic                  cfg_valid;
    logic                  cfg_ready;

    modport master (output cfg_word, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_word, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/cgra_config_loader.sv
// Serial loader: shifts host words LSB-first into the CGRA config chain,
// stopping after exactly CHAIN_BITS bits and pulsing done once.
module cgra_config_loader #(
    parameter int WORD_WIDTH = 32,
    parameter int CHAIN_BITS = 552
) (
    input  logic                 Config_Clock,
    input  logic                 Config_Reset,
    input  logic                 start,
    input  logic                 abort,
    cgra_config_loader_if.slave  cfg,
    output logic                 ConfigOut,
    output logic                 config_clk_en,
    output logic                 busy,
    output logic                 done
);
    localparam int NUM_WORDS = (CHAIN_BITS + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int BCNT_W    = $clog2(WORD_WIDTH + 1);
    localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
    localparam int REM_W     = $clog2(CHAIN_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] sreg_q,  sreg_d;
    logic [BCNT_W-1:0]     bcnt_q,  bcnt_d;
    logic [WCNT_W-1:0]     wcnt_q,  wcnt_d;
    logic [REM_W-1:0]      rem_q,   rem_d;

    logic             ready;
    logic             shift;
    logic             load;
    logic [REM_W-1:0] take;

    assign cfg.cfg_ready = ready;

    // Bits granted to the next word: the final word only carries what the chain still needs.
    always_comb begin
        take = rem_q;
        if (32'(rem_q) >= 32'(WORD_WIDTH)) take = REM_W'(WORD_WIDTH);
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d       = state_q;
        sreg_d        = sreg_q;
        bcnt_d        = bcnt_q;
        wcnt_d        = wcnt_q;
        rem_d         = rem_q;
        ready         = 1'b0;
        shift         = 1'b0;
        load          = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        config_clk_en = 1'b0;
        ConfigOut     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    wcnt_d  = '0;
                    rem_d   = REM_W'(CHAIN_BITS);
                    bcnt_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy  = 1'b1;
                // Accepting while the last bit drains keeps consecutive words bubble-free.
                ready = (bcnt_q <= BCNT_W'(1)) && (wcnt_q < WCNT_W'(NUM_WORDS)) && !abort;
                shift = (bcnt_q != '0);
                load  = cfg.cfg_valid && ready;
                if (shift) begin
                    config_clk_en = 1'b1;
                    ConfigOut     = sreg_q[0];
                    sreg_d        = sreg_q >> 1;
                    bcnt_d        = bcnt_q - 1'b1;
                end
                if (load) begin
                    sreg_d = cfg.cfg_word;
                    bcnt_d = BCNT_W'(take);
                    rem_d  = rem_q - take;
                    wcnt_d = wcnt_q + 1'b1;
                end
                if (shift && !load && bcnt_q == BCNT_W'(1) && rem_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge Config_Clock) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (Config_Reset) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            rem_q   <= rem_d;
        end
    end
endmodule

// File: tb/tb_cgra_config_loader.sv
// Randomized scoreboard bench for cgra_config_loader: three instances
// (46-bit, 552-bit and 64-bit chains) share one clock.
module tb_cgra_config_loader;
    logic        clk;
    logic [2:0]  rst, start, abort, valid, ready, cout, en, busy, done;
    logic [31:0] word [3];

    bit exp_q [3][$];
    int shifts [3];
    int gaps [3];
    int run [3];
    int max_run [3];
    int done_cnt [3];
    bit done_exp [3];
    bit in_stream [3];
    bit prev_en [3];
    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CBG = (g == 0) ? 46 : (g == 1) ? 552 : 64;
        cgra_config_loader_if #(.WORD_WIDTH(32)) bus ();
        assign bus.cfg_word  = word[g];
        assign bus.cfg_valid = valid[g];
        assign ready[g]      = bus.cfg_ready;
        cgra_config_loader #(.WORD_WIDTH(32), .CHAIN_BITS(CBG)) u_dut (
            .Config_Clock (clk),
            .Config_Reset (rst[g]),
            .start        (start[g]),
            .abort        (abort[g]),
            .cfg          (bus.slave),
            .ConfigOut    (cout[g]),
            .config_clk_en(en[g]),
            .busy         (busy[g]),
            .done         (done[g])
        );
    end

    function automatic int cb(input int i);
        return (i == 0) ? 46 : (i == 1) ? 552 : 64;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every enabled cycle pops the next expected chain bit.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                if (exp_q[i].size() == 0) check($sformatf("d%0d_unexpected_shift", i), 1, 0);
                else check($sformatf("d%0d_bit%0d", i, shifts[i]), 32'(cout[i]), 32'(exp_q[i].pop_front()));
                shifts[i]++;
                run[i]++;
                if (run[i] > max_run[i]) max_run[i] = run[i];
                in_stream[i] = 1'b1;
            end else begin
                check($sformatf("d%0d_idle_out_zero", i), 32'(cout[i]), 0);
                if (busy[i] && in_stream[i]) gaps[i]++;
                run[i] = 0;
            end
            if (done[i]) begin
                check($sformatf("d%0d_done_expected", i), 32'(done_exp[i]), 1);
                check($sformatf("d%0d_done_after_last_shift", i), 32'(prev_en[i]), 1);
                check($sformatf("d%0d_done_all_bits_out", i), exp_q[i].size(), 0);
                check($sformatf("d%0d_done_not_busy", i), 32'(busy[i]), 0);
                done_exp[i]  = 1'b0;
                done_cnt[i]++;
                in_stream[i] = 1'b0;
            end
            prev_en[i] = en[i];
        end
    end

    // One complete host session on instance i, optionally stalled, killed or poked with start.
    task automatic run_load(input int i, input bit fixed, input int stall_len, input int kill_at,
                            input bit kill_rst, input int start_load_at, input bit start_done);
        logic [31:0] words[$];
        logic [31:0] wv;
        int nb, nw, w, hs_n, stall_left, done0, kill_phase;
        bit hs, ready_chk, finished, start_sent;
        nb = cb(i);
        nw = (nb + 31) / 32;
        for (int k = 0; k < nw; k++) begin
            if (fixed && k == 0)      words.push_back(32'hA5A5_F00F);
            else if (fixed && k == 1) words.push_back(32'h0000_3ABC);
            else                      words.push_back($urandom());
        end
        // Reference: the chain receives the first nb bits of the word list, LSB of word 0 first.
        for (int b = 0; b < nb; b++) begin
            wv = words[b / 32];
            exp_q[i].push_back(wv[b % 32]);
        end
        shifts[i] = 0; gaps[i] = 0; run[i] = 0; max_run[i] = 0;
        in_stream[i] = 1'b0; done_exp[i] = 1'b1; done0 = done_cnt[i];
        w = 0; hs_n = 0; stall_left = 0; kill_phase = 0;
        ready_chk = 1'b0; finished = 1'b0; start_sent = 1'b0;

        @(posedge clk); #1;
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        valid[i] = 1'b1;
        word[i]  = words[0];
        @(negedge clk); #1;
        check($sformatf("d%0d_busy_cycle1", i), 32'(busy[i]), 1);
        check($sformatf("d%0d_ready_cycle1", i), 32'(ready[i]), 1);

        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            hs = valid[i] && ready[i];
            if (!valid[i] && ready[i] && stall_left > 0) stall_left--;
            if (w == nw && !ready_chk) begin
                check($sformatf("d%0d_ready_low_after_last_word", i), 32'(ready[i]), 0);
                ready_chk = 1'b1;
            end
            if (kill_phase == 2) begin
                check($sformatf("d%0d_kill_clk_en", i), 32'(en[i]), 0);
                check($sformatf("d%0d_kill_busy", i), 32'(busy[i]), 0);
                check($sformatf("d%0d_kill_ready", i), 32'(ready[i]), 0);
                check($sformatf("d%0d_kill_out", i), 32'(cout[i]), 0);
                check($sformatf("d%0d_kill_done", i), 32'(done[i]), 0);
                check($sformatf("d%0d_kill_shift_count", i), shifts[i], kill_at);
                finished = 1'b1;
            end else if (done_cnt[i] != done0) begin
                finished = 1'b1;
            end else begin
                @(posedge clk); #1;
                start[i] = 1'b0;
                if (hs) begin
                    w++;
                    hs_n++;
                    if (w == 1) stall_left = stall_len;
                end
                if (kill_phase == 1) begin
                    abort[i] = 1'b0;
                    rst[i]   = 1'b0;
                    valid[i] = 1'b0;
                    exp_q[i].delete();
                    done_exp[i] = 1'b0;
                    kill_phase  = 2;
                end else begin
                    valid[i] = (w < nw) && (stall_left == 0);
                    if (w < nw) word[i] = words[w];
                    if (kill_at > 0 && shifts[i] == kill_at - 1) begin
                        if (kill_rst) rst[i] = 1'b1;
                        else abort[i] = 1'b1;
                        kill_phase = 1;
                    end
                    if (start_load_at > 0 && shifts[i] == start_load_at) start[i] = 1'b1;
                    if (start_done && shifts[i] == nb && !start_sent) begin
                        start[i]   = 1'b1;
                        start_sent = 1'b1;
                    end
                end
                @(negedge clk); #1;
            end
        end
        if (!finished) check($sformatf("d%0d_timeout", i), 0, 1);

        @(posedge clk); #1;
        start[i] = 1'b0;
        valid[i] = 1'b0;
        if (kill_at == 0) begin
            check($sformatf("d%0d_shift_count", i), shifts[i], nb);
            check($sformatf("d%0d_handshakes", i), hs_n, nw);
            check($sformatf("d%0d_stall_gaps", i), gaps[i], stall_len);
            check($sformatf("d%0d_queue_drained", i), exp_q[i].size(), 0);
            check($sformatf("d%0d_done_pulses", i), done_cnt[i] - done0, 1);
            if (stall_len == 0) check($sformatf("d%0d_contiguous_run", i), max_run[i], nb);
        end
        repeat (3) @(negedge clk);
        #1;
        check($sformatf("d%0d_idle_after_session", i), 32'(busy[i]), 0);
        check($sformatf("d%0d_no_extra_done", i), done_cnt[i] - done0, (kill_at == 0) ? 1 : 0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = '1; start = '0; abort = '0; valid = '0;
        for (int k = 0; k < 3; k++) word[k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("d%0d_rst_ready", i), 32'(ready[i]), 0);
            check($sformatf("d%0d_rst_out", i), 32'(cout[i]), 0);
            check($sformatf("d%0d_rst_clk_en", i), 32'(en[i]), 0);
            check($sformatf("d%0d_rst_busy", i), 32'(busy[i]), 0);
            check($sformatf("d%0d_rst_done", i), 32'(done[i]), 0);
        end
        @(posedge clk); #1;
        rst = '0;

        run_load(0, 1'b1, 0, 0, 1'b0, 0, 1'b0);     // 46-bit chain, fixed words
        run_load(1, 1'b0, 0, 0, 1'b0, 50, 1'b1);    // 552-bit, start poked in LOAD and DONE
        run_load(0, 1'b1, 5, 0, 1'b0, 0, 1'b0);     // host stall after first word
        run_load(1, 1'b0, 0, 20, 1'b0, 0, 1'b0);    // abort on 20th shift
        run_load(1, 1'b0, 0, 0, 1'b0, 0, 1'b0);     // clean reload after abort
        run_load(1, 1'b0, 0, 100, 1'b1, 0, 1'b0);   // reset mid-load
        run_load(1, 1'b0, 0, 0, 1'b0, 0, 1'b0);     // clean reload after reset
        run_load(2, 1'b0, 0, 0, 1'b0, 0, 1'b0);     // exact multiple of the word width
        run_load(2, 1'b0, 3, 0, 1'b0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
